alu_issue_sched: RTL and testbench

ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

---
 rtl/alu_issue_sched.sv | 123 ++++++++++++
 tb/tb_alu_issue_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// Issue scheduler: picks ready reservation-station entries round-robin and
// hands them to free ALUs, tracking each ALU's undrained result and a saturating issue count.

module alu_issue_slot (
    input  logic clock,
    input  logic reset,
    input  logic squash,
    input  logic issue,
    input  logic grant,
    output logic busy,
    output logic stall,
    output logic avail
);
    typedef enum logic {EMPTY, HELD} slot_state_e;

    slot_state_e state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // A new issue wins over a drain in the same cycle, so the slot stays HELD.
    always_comb begin
        state_d = state_q;
        if (squash)     state_d = EMPTY;
        else if (issue) state_d = HELD;
        else if (grant) state_d = EMPTY;
    end

    assign busy  = (state_q == HELD);
    assign stall = busy & ~grant & ~reset;
    assign avail = ~busy | grant;
endmodule

module alu_issue_sched #(
    parameter int RS_SZ   = 8,
    parameter int NUM_ALU = 2,
    localparam int IDX_W  = $clog2(RS_SZ)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [RS_SZ-1:0]                  rs_ready,
    input  logic [NUM_ALU-1:0]                cdb_grant,
    input  logic                              squash,
    output logic [NUM_ALU-1:0]                issue_valid,
    output logic [NUM_ALU-1:0][IDX_W-1:0]     issue_idx,
    output logic [NUM_ALU-1:0]                alu_stall,
    output logic [NUM_ALU-1:0]                alu_rd_in,
    output logic [RS_SZ-1:0]                  rs_clear,
    output logic [NUM_ALU-1:0]                alu_busy,
    output logic [31:0]                       issue_cnt
);
    logic [NUM_ALU-1:0] avail;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, scan_idx;
    logic               placed;
    logic [31:0]        cnt_q, cnt_nxt;
    logic [32:0]        cnt_sum;

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_slot
        alu_issue_slot u_slot (
            .clock  (clock),
            .reset  (reset),
            .squash (squash),
            .issue  (issue_valid[k]),
            .grant  (cdb_grant[k]),
            .busy   (alu_busy[k]),
            .stall  (alu_stall[k]),
            .avail  (avail[k])
        );
    end

    // Circular scan from rr_ptr; each ready entry goes to the lowest free ALU.
    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        rs_clear    = '0;
        rr_nxt      = rr_ptr;
        scan_idx    = '0;
        placed      = 1'b0;
        for (int j = 0; j < RS_SZ; j++) begin
            scan_idx = rr_ptr + IDX_W'(j);
            placed   = 1'b0;
            if (rs_ready[scan_idx]) begin
                for (int k = 0; k < NUM_ALU; k++) begin
                    if (!placed && avail[k] && !issue_valid[k]) begin
                        issue_valid[k]     = 1'b1;
                        issue_idx[k]       = scan_idx;
                        rs_clear[scan_idx] = 1'b1;
                        rr_nxt             = scan_idx + IDX_W'(1);
                        placed             = 1'b1;
                    end
                end
            end
        end
        if (reset || squash) begin
            issue_valid = '0;
            issue_idx   = '0;
            rs_clear    = '0;
            rr_nxt      = rr_ptr;
        end
    end

    assign alu_rd_in = issue_valid;

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int k = 0; k < NUM_ALU; k++) cnt_sum = cnt_sum + 33'(issue_valid[k]);
        cnt_nxt = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            rr_ptr <= rr_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign issue_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized and directed checks of alu_issue_sched against a queue-based reference model.

module tb_alu_issue_sched;
    localparam int RS_SZ   = 8;
    localparam int NUM_ALU = 2;
    localparam int IDX_W   = $clog2(RS_SZ);

    logic                          clock = 1'b0;
    logic                          reset = 1'b1;
    logic [RS_SZ-1:0]              rs_ready = '0;
    logic [NUM_ALU-1:0]            cdb_grant = '0;
    logic                          squash = 1'b0;
    logic [NUM_ALU-1:0]            issue_valid;
    logic [NUM_ALU-1:0][IDX_W-1:0] issue_idx;
    logic [NUM_ALU-1:0]            alu_stall;
    logic [NUM_ALU-1:0]            alu_rd_in;
    logic [RS_SZ-1:0]              rs_clear;
    logic [NUM_ALU-1:0]            alu_busy;
    logic [31:0]                   issue_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [NUM_ALU-1:0] m_held = '0;
    int                 m_rr   = 0;
    longint             m_cnt  = 0;

    alu_issue_sched #(.RS_SZ(RS_SZ), .NUM_ALU(NUM_ALU)) dut (
        .clock       (clock),
        .reset       (reset),
        .rs_ready    (rs_ready),
        .cdb_grant   (cdb_grant),
        .squash      (squash),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .alu_stall   (alu_stall),
        .alu_rd_in   (alu_rd_in),
        .rs_clear    (rs_clear),
        .alu_busy    (alu_busy),
        .issue_cnt   (issue_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check every output against the model, advance the model.
    task automatic step(input logic [RS_SZ-1:0] rs, input logic [NUM_ALU-1:0] gr,
                        input logic sq, input logic rst);
        logic [NUM_ALU-1:0] e_valid, e_stall;
        logic [RS_SZ-1:0]   e_clear;
        int                 e_idx[NUM_ALU];
        int                 free_q[$];
        int                 last, k, n;
        bit                 any;
        @(posedge clock);
        #1;
        rs_ready = rs; cdb_grant = gr; squash = sq; reset = rst;
        @(negedge clock);
        e_valid = '0; e_stall = '0; e_clear = '0; any = 0; last = 0; n = 0;
        for (int a = 0; a < NUM_ALU; a++) begin
            e_idx[a] = 0;
            if (!m_held[a] || gr[a]) free_q.push_back(a);
            e_stall[a] = !rst && m_held[a] && !gr[a];
        end
        if (!rst && !sq) begin
            for (int j = 0; j < RS_SZ; j++) begin
                int i;
                i = (m_rr + j) % RS_SZ;
                if (rs[i] && free_q.size() > 0) begin
                    k = free_q.pop_front();
                    e_valid[k] = 1'b1; e_idx[k] = i; e_clear[i] = 1'b1;
                    last = i; any = 1; n++;
                end
            end
        end
        chk("issue_valid", 64'(issue_valid), 64'(e_valid));
        chk("rs_clear",    64'(rs_clear),    64'(e_clear));
        chk("alu_rd_in",   64'(alu_rd_in),   64'(e_valid));
        chk("alu_stall",   64'(alu_stall),   64'(e_stall));
        chk("alu_busy",    64'(alu_busy),    64'(m_held));
        chk("issue_cnt",   64'(issue_cnt),   64'(m_cnt));
        for (int a = 0; a < NUM_ALU; a++) chk($sformatf("issue_idx%0d", a), 64'(issue_idx[a]), 64'(e_idx[a]));
        if (rst) begin
            m_held = '0; m_rr = 0; m_cnt = 0;
        end else begin
            for (int a = 0; a < NUM_ALU; a++) begin
                if (sq)              m_held[a] = 1'b0;
                else if (e_valid[a]) m_held[a] = 1'b1;
                else if (gr[a])      m_held[a] = 1'b0;
            end
            if (any) m_rr = (last + 1) % RS_SZ;
            m_cnt = m_cnt + n;
            if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        end
    endtask

    initial begin
        step('0, '0, 1'b0, 1'b1);
        step(8'hFF, '0, 1'b0, 1'b1);
        chk("rst_valid", 64'(issue_valid), 64'h0);

        // basic two-way issue after reset
        step(8'h06, 2'b00, 1'b0, 1'b0);
        chk("d31_valid", 64'(issue_valid), 64'h3);
        chk("d31_idx0",  64'(issue_idx[0]), 64'd1);
        chk("d31_idx1",  64'(issue_idx[1]), 64'd2);
        chk("d31_clear", 64'(rs_clear), 64'h06);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        chk("d31_busy", 64'(alu_busy), 64'h3);

        // walk rr_ptr to 6 with both ALUs empty, then wrap
        step(8'h00, 2'b00, 1'b1, 1'b0);
        step(8'h20, 2'b00, 1'b0, 1'b0);
        step(8'h00, 2'b01, 1'b0, 1'b0);
        step(8'h81, 2'b00, 1'b0, 1'b0);
        chk("d32_idx0", 64'(issue_idx[0]), 64'd7);
        chk("d32_idx1", 64'(issue_idx[1]), 64'd0);

        // rr_ptr back to 0 with both held, then partial drain
        step(8'h80, 2'b10, 1'b0, 1'b0);
        step(8'hFF, 2'b01, 1'b0, 1'b0);
        chk("d33_stall", 64'(alu_stall), 64'h2);
        chk("d33_valid", 64'(issue_valid), 64'h1);
        chk("d33_idx0",  64'(issue_idx[0]), 64'd0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        chk("d33_busy", 64'(alu_busy), 64'h3);

        // squash with everything held
        step(8'hFF, 2'b00, 1'b1, 1'b0);
        chk("d34_valid", 64'(issue_valid), 64'h0);
        chk("d34_clear", 64'(rs_clear), 64'h0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        chk("d34_busy", 64'(alu_busy), 64'h0);
        step(8'hFF, 2'b00, 1'b0, 1'b0);
        chk("d34_rr_idx0", 64'(issue_idx[0]), 64'd1);
        chk("d34_rr_idx1", 64'(issue_idx[1]), 64'd2);

        // reset while held
        step(8'hFF, 2'b00, 1'b0, 1'b1);
        chk("d36_valid", 64'(issue_valid), 64'h0);
        chk("d36_stall", 64'(alu_stall), 64'h0);
        step(8'h00, 2'b00, 1'b0, 1'b0);
        chk("d36_busy", 64'(alu_busy), 64'h0);
        chk("d36_cnt",  64'(issue_cnt), 64'h0);

        // counter saturation with a preloaded count
        @(posedge clock);
        #1;
        rs_ready = 8'h03; cdb_grant = '0; squash = 1'b0; reset = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFD;
        #1 chk("sat_fffd", 64'(dut.cnt_nxt), 64'hFFFF_FFFF);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1 chk("sat_fffe", 64'(dut.cnt_nxt), 64'hFFFF_FFFF);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 chk("sat_ffff", 64'(dut.cnt_nxt), 64'hFFFF_FFFF);
        force dut.cnt_q = 32'hFFFF_FFFC;
        #1 chk("sat_fffc", 64'(dut.cnt_nxt), 64'hFFFF_FFFE);
        release dut.cnt_q;
        rs_ready = '0; reset = 1'b1;
        m_held = '0; m_rr = 0; m_cnt = 0;
        step('0, '0, 1'b0, 1'b1);

        for (int c = 0; c < 400; c++)
            step(RS_SZ'($urandom), NUM_ALU'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
